ham_dec_pipe: RTL and testbench
===============================

Name: ham_dec_pipe

Overview:
Pipelined single-error-correcting decoder for the team's 17-bit Hamming codeword, which carries 12 info bits plus 5 parity bits. It sits at the receive end of a link after the codeword register. It computes the syndrome, corrects any single-bit error, flags syndromes that cannot be corrected, and keeps saturating error counters. Input and output both use valid/ready handshakes with full throughput and backpressure.

Parameters:
CNT_W, 16, width of each saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  codeword present
in_ready  output  1  decoder can accept a codeword
codeword  input  17  received word; bit i is Hamming position i+1
out_valid  output  1  decoded result present
out_ready  input  1  sink accepts the result
info_bits  output  12  decoded (corrected) info bits
syndrome  output  5  syndrome of the word; 0 means no error
err_corr  output  1  single error corrected (syndrome 1..17)
err_uncorr  output  1  syndrome 18..31; data passed through uncorrected
cnt_clr  input  1  synchronous clear of both counters
corr_cnt  output  CNT_W  count of err_corr results delivered
uncorr_cnt  output  CNT_W  count of err_uncorr results delivered

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Bit layout. Parity bits sit at indices 0, 1, 3, 7, 15 (positions 1, 2, 4, 8, 16).
  - info[0] is at cw[2]; info[1..3] at cw[4..6]; info[4..10] at cw[8..14]; info[11] at cw[16].
- Syndrome: bit k = XOR of every cw[i] where bit k of (i+1) is 1, for k = 0..4.
  - Bit 0 covers indices 0,2,4,6,8,10,12,14,16.
  - Bit 4 covers indices 15 and 16.
- Stage 1, on input transfer (in_valid && in_ready): register the codeword and its syndrome together with a valid bit s1_v.
- Stage 2, on the s1→s2 advance:
  - Syndrome s in 1..17: flip cw[s-1], then extract the info bits.
  - Syndrome 0: extract the info bits unchanged.
  - Syndrome 18..31: extract the info bits from the uncorrected word; err_uncorr=1.
  - Register info_bits, syndrome, err_corr, err_uncorr and out_valid.
- Flags: err_corr and err_uncorr are mutually exclusive. A double error is not detected as such and may be miscorrected (SEC only, by design).
- Flow control:
  - s2 advance when s1_v && (!out_valid || out_ready).
  - in_ready = !s1_v || !out_valid || out_ready. It is combinational and must not depend on in_valid.
  - out_valid clears on an output transfer when no new s1 data advances.
  - Outputs hold stable while out_valid && !out_ready.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 word per cycle with out_ready held high.
- Counters:
  - Increment on an output transfer (out_valid && out_ready) whose err_corr or err_uncorr is 1.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr wins over a simultaneous increment: the result is 0.
- Reset values: out_valid=0, s1_v=0, info_bits=0, syndrome=0, err_corr=0, err_uncorr=0, corr_cnt=0, uncorr_cnt=0. in_ready=1 after reset.
- Reset mid-operation: in-flight words in both stages are discarded and never appear at the output. Counters clear.
- Stall boundary: with both stages full and out_ready=0, in_ready=0 and no data is lost or duplicated. On release, words emerge in order, one per cycle.

Test Plan:
- Clean words: codeword 17'h00000 then 17'h1FFFE, out_ready=1 → two cycles later info_bits 12'h000 then 12'hFFF, syndrome 0, no flags, counters stay 0.
- Single error, data bit: 17'h00000 with cw[5] flipped (17'h00020) → syndrome 6, info_bits 12'h000, err_corr=1, corr_cnt=1.
- Single error, last position: 17'h0FFFE (cw[16] flipped from 17'h1FFFE) → syndrome 17, info_bits 12'hFFF, err_corr=1.
- Uncorrectable: 17'h08002 → syndrome 18, err_uncorr=1, info_bits 12'h000, uncorr_cnt=1.
- Backpressure: stream 5 distinct words with out_ready low for 4 cycles mid-stream.
  - in_ready drops after 2 words are held.
  - All 5 words appear in order with no duplicates.
  - Counters count each erroneous word exactly once.
- Saturation, clear and reset:
  - CNT_W=2, send 5 corrected words → corr_cnt=3.
  - Assert cnt_clr in the same cycle as an erroneous output transfer → counter reads 0.
  - Assert rst with both stages full → out_valid=0 the next cycle and no stale output afterwards.

Source files
------------

// File: rtl/ham_dec_pipe.sv
// ham_dec_pipe: two-stage pipelined SEC decoder for the 17-bit Hamming
// codeword (12 info bits + 5 parity bits at positions 1, 2, 4, 8, 16).
//
// Stage 1 registers the received word with its syndrome. Stage 2 corrects
// a single-bit error (syndrome 1..17), passes the word through untouched for
// syndromes 18..31 (flagged uncorrectable), extracts the info bits and holds
// the result until the sink takes it. Saturating counters tally corrected and
// uncorrectable results as they are delivered.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake, codeword[16:0] (bit i = position i+1)
//   out_valid / out_ready output handshake
//   info_bits[11:0]       decoded info bits
//   syndrome[4:0]         syndrome of the received word (0 = clean)
//   err_corr, err_uncorr  single error corrected / uncorrectable syndrome
//   cnt_clr               synchronous clear of both counters
//   corr_cnt, uncorr_cnt  saturating counts of flagged results delivered
module ham_dec_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      info_bits,
  output logic [4:0]       syndrome,
  output logic             err_corr,
  output logic             err_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // XOR of the positions of all set bits; equals the per-bit parity checks.
  function automatic logic [4:0] calcSyndrome(input logic [16:0] cw);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 17; i++) begin
      if (cw[i]) s = s ^ 5'(i + 1);
    end
    return s;
  endfunction

  logic             s1V_q;
  logic [16:0]      s1Cw_q;
  logic [4:0]       s1Syn_q;

  logic             outValid_q;
  logic [11:0]      info_q;
  logic [4:0]       syn_q;
  logic             corr_q;
  logic             uncorr_q;
  logic [CNT_W-1:0] corrCnt_q;
  logic [CNT_W-1:0] uncorrCnt_q;

  logic             advance;
  logic             inXfer;
  logic             outXfer;
  logic [16:0]      flipMask_d;
  logic [16:0]      fixedCw_d;
  logic [11:0]      info_d;
  logic             corr_d;
  logic             uncorr_d;

  // Stage 2 takes new data when it is empty or being drained this cycle.
  assign advance  = s1V_q && (!outValid_q || out_ready);
  assign in_ready = !s1V_q || !outValid_q || out_ready;
  assign inXfer   = in_valid && in_ready;
  assign outXfer  = outValid_q && out_ready;

  // Syndromes 18..31 match no position, so the mask stays zero for them.
  always_comb begin
    flipMask_d = '0;
    for (int i = 0; i < 17; i++) begin
      flipMask_d[i] = (s1Syn_q == 5'(i + 1));
    end
    fixedCw_d = s1Cw_q ^ flipMask_d;
    info_d    = {fixedCw_d[16], fixedCw_d[14:8], fixedCw_d[6:4], fixedCw_d[2]};
    corr_d    = (s1Syn_q != 5'd0) && (s1Syn_q <= 5'd17);
    uncorr_d  = (s1Syn_q >= 5'd18);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1V_q   <= 1'b0;
      s1Cw_q  <= '0;
      s1Syn_q <= '0;
    end else if (inXfer) begin
      s1V_q   <= 1'b1;
      s1Cw_q  <= codeword;
      s1Syn_q <= calcSyndrome(codeword);
    end else if (advance) begin
      s1V_q   <= 1'b0;
    end
  end

  // Result register holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      info_q     <= '0;
      syn_q      <= '0;
      corr_q     <= 1'b0;
      uncorr_q   <= 1'b0;
    end else if (advance) begin
      outValid_q <= 1'b1;
      info_q     <= info_d;
      syn_q      <= s1Syn_q;
      corr_q     <= corr_d;
      uncorr_q   <= uncorr_d;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corrCnt_q   <= '0;
      uncorrCnt_q <= '0;
    end else if (outXfer) begin
      if (corr_q && (corrCnt_q != '1))
        corrCnt_q <= corrCnt_q + CNT_W'(1);
      if (uncorr_q && (uncorrCnt_q != '1))
        uncorrCnt_q <= uncorrCnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = outValid_q;
  assign info_bits  = info_q;
  assign syndrome   = syn_q;
  assign err_corr   = corr_q;
  assign err_uncorr = uncorr_q;
  assign corr_cnt   = corrCnt_q;
  assign uncorr_cnt = uncorrCnt_q;

endmodule

// File: tb/tb_ham_dec_pipe.sv
// tb_ham_dec_pipe: self-checking bench for ham_dec_pipe. Two instances share
// all inputs: one with the default 16-bit counters and one with 2-bit
// counters to reach saturation quickly. A queue-based decode model tracks
// every accepted word and is compared against both DUTs on every cycle;
// directed tests add hand-computed literal expectations.
module tb_ham_dec_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [16:0] codeword;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [11:0] info_bits, info_bits2;
  logic [4:0]  syndrome,  syndrome2;
  logic        err_corr,  err_corr2;
  logic        err_uncorr, err_uncorr2;
  logic [15:0] corr_cnt,  uncorr_cnt;
  logic [1:0]  corr_cnt2, uncorr_cnt2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [11:0] info;
    logic [4:0]  syn;
    logic        c;
    logic        u;
  } res_t;

  res_t q[$];
  int   corrM, uncorrM, corr2M, uncorr2M;
  int   delivered = 0;
  bit   armed = 0;

  ham_dec_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .out_valid(out_valid), .out_ready(out_ready),
    .info_bits(info_bits), .syndrome(syndrome), .err_corr(err_corr),
    .err_uncorr(err_uncorr), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  ham_dec_pipe #(.CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .codeword(codeword), .out_valid(out_valid2), .out_ready(out_ready),
    .info_bits(info_bits2), .syndrome(syndrome2), .err_corr(err_corr2),
    .err_uncorr(err_uncorr2), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt2),
    .uncorr_cnt(uncorr_cnt2)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Decode from first principles: syndrome = XOR of set positions,
  // info bits = non-power-of-two positions in ascending order.
  function automatic res_t modelDecode(input logic [16:0] cwIn);
    res_t        r;
    logic [16:0] cw;
    int          s;
    int          n;
    cw = cwIn;
    s  = 0;
    for (int p = 1; p <= 17; p++) if (cw[p-1]) s = s ^ p;
    r.syn = 5'(s);
    r.c   = (s >= 1 && s <= 17);
    r.u   = (s >= 18);
    if (r.c) cw[s-1] = ~cw[s-1];
    r.info = '0;
    n = 0;
    for (int p = 1; p <= 17; p++) begin
      if ((p & (p - 1)) != 0) begin
        r.info[n] = cw[p-1];
        n++;
      end
    end
    return r;
  endfunction

  function automatic int satInc(input int v, input int maxV);
    return (v < maxV) ? v + 1 : v;
  endfunction

  // Compare DUT outputs against the model at each falling edge, then
  // advance the model by the transfers that the coming rising edge performs.
  always @(negedge clk) begin
    res_t h;
    if (armed) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
      check("in_ready sat", {31'd0, in_ready2}, {31'd0, (q.size() < 2) || out_ready});
      if (q.size() == 0) begin
        check("out_valid idle", {31'd0, out_valid}, 32'd0);
        check("out_valid idle sat", {31'd0, out_valid2}, 32'd0);
      end else begin
        if (q.size() == 2) begin
          check("out_valid full", {31'd0, out_valid}, 32'd1);
          check("out_valid full sat", {31'd0, out_valid2}, 32'd1);
        end
        if (out_valid === 1'b1)
          check("result", {13'd0, info_bits, syndrome, err_corr, err_uncorr}, {13'd0, q[0]});
        if (out_valid2 === 1'b1)
          check("result sat", {13'd0, info_bits2, syndrome2, err_corr2, err_uncorr2}, {13'd0, q[0]});
      end
      check("corr_cnt", {16'd0, corr_cnt}, corrM);
      check("uncorr_cnt", {16'd0, uncorr_cnt}, uncorrM);
      check("corr_cnt sat", {30'd0, corr_cnt2}, corr2M);
      check("uncorr_cnt sat", {30'd0, uncorr_cnt2}, uncorr2M);
    end
    if (rst) begin
      q.delete();
      corrM = 0; uncorrM = 0; corr2M = 0; uncorr2M = 0;
      armed = 1;
    end else if (armed) begin
      if (out_valid && out_ready && q.size() > 0) begin
        h = q.pop_front();
        delivered++;
        if (h.c) begin corrM = satInc(corrM, 65535); corr2M = satInc(corr2M, 3); end
        if (h.u) begin uncorrM = satInc(uncorrM, 65535); uncorr2M = satInc(uncorr2M, 3); end
      end
      if (cnt_clr) begin
        corrM = 0; uncorrM = 0; corr2M = 0; uncorr2M = 0;
      end
      if (in_valid && in_ready) q.push_back(modelDecode(codeword));
    end
  end

  // Send one word into an empty pipeline and stop at the cycle its result
  // must be visible; confirms it is not visible one cycle earlier.
  task automatic applyStimulus(input logic [16:0] cw);
    @(posedge clk); #1;
    in_valid = 1'b1;
    codeword = cw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [11:0] expInfo,
                             input logic [4:0] expSyn, input logic expC, input logic expU);
    check({name, " valid"}, {31'd0, out_valid}, 32'd1);
    check({name, " info"}, {20'd0, info_bits}, {20'd0, expInfo});
    check({name, " syndrome"}, {27'd0, syndrome}, {27'd0, expSyn});
    check({name, " flags"}, {30'd0, err_corr, err_uncorr}, {30'd0, expC, expU});
  endtask

  logic [16:0] words [5];

  initial begin
    int i;
    int c;
    int startDelivered;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; codeword = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset info", {20'd0, info_bits}, 32'd0);
    check("reset syndrome", {27'd0, syndrome}, 32'd0);
    check("reset flags", {30'd0, err_corr, err_uncorr}, 32'd0);
    check("reset counts", {corr_cnt, uncorr_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(17'h00000);
    checkOutput("clean zero", 12'h000, 5'd0, 1'b0, 1'b0);
    applyStimulus(17'h1FFFE);
    checkOutput("clean ones", 12'hFFF, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("clean counts", {corr_cnt, uncorr_cnt}, 32'd0);

    applyStimulus(17'h00020);
    checkOutput("data bit err", 12'h000, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    check("corr_cnt after one", {16'd0, corr_cnt}, 32'd1);

    applyStimulus(17'h0FFFE);
    checkOutput("last pos err", 12'hFFF, 5'd17, 1'b1, 1'b0);

    applyStimulus(17'h08002);
    checkOutput("uncorrectable", 12'h000, 5'd18, 1'b0, 1'b1);
    @(negedge clk);
    check("uncorr_cnt after one", {16'd0, uncorr_cnt}, 32'd1);
    check("corr_cnt before stream", {16'd0, corr_cnt}, 32'd2);

    // Backpressure: five words, sink stalled for four cycles mid-stream.
    words[0] = 17'h00004; words[1] = 17'h1FFFE; words[2] = 17'h00001;
    words[3] = 17'h10000; words[4] = 17'h08002;
    startDelivered = delivered;
    i = 0; c = 0; acc = 1'b0;
    while (i < 5 && c < 60) begin
      @(posedge clk);
      if (acc) i++;
      #1;
      out_ready = !(c >= 2 && c < 6);
      in_valid  = (i < 5);
      codeword  = (i < 5) ? words[i] : 17'h0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 3) check("in_ready stalled", {31'd0, in_ready}, 32'd0);
      c++;
    end
    check("stream accepted", i, 5);
    c = 0;
    while (q.size() != 0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("stream drained", q.size(), 0);
    check("stream delivered", delivered - startDelivered, 5);
    @(negedge clk);
    check("corr_cnt after stream", {16'd0, corr_cnt}, 32'd5);
    check("uncorr_cnt after stream", {16'd0, uncorr_cnt}, 32'd2);

    // Clear coinciding with an erroneous output transfer.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; codeword = 17'h00020;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    check("held before clear", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clear wins corr", {16'd0, corr_cnt}, 32'd0);
    check("clear wins corr sat", {30'd0, corr_cnt2}, 32'd0);
    check("clear wins uncorr", {16'd0, uncorr_cnt}, 32'd0);

    // Saturation of the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(17'h00020);
      checkOutput("sat word", 12'h000, 5'd6, 1'b1, 1'b0);
    end
    @(negedge clk);
    check("sat corr_cnt2", {30'd0, corr_cnt2}, 32'd3);
    check("sat corr_cnt", {16'd0, corr_cnt}, 32'd5);

    // Reset with both stages full.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; codeword = 17'h00020;
    @(posedge clk); #1;
    codeword = 17'h00004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("full out_valid", {31'd0, out_valid}, 32'd1);
    check("full in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("post reset out_valid", {31'd0, out_valid}, 32'd0);
    check("post reset in_ready", {31'd0, in_ready}, 32'd1);
    check("post reset counts", {corr_cnt, uncorr_cnt}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("no stale output", {31'd0, out_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
